aoi_vector_checker: RTL and testbench
=====================================

AOI_VECTOR_CHECKER -- requirements
Module: aoi_vector_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of wait cycles between driving a vector and sampling the response (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit, a single-cycle request to run the full vector sweep.
REQ-005 SHALL have port vec_out, output, 4 bits, stimulus to the AOI gate under test: [0]=A, [1]=B, [2]=C, [3]=D.
REQ-006 SHALL have ports e_in, f_in and g_in, input, 1 bit each, the E, F and G responses of the gate under test.
REQ-007 SHALL have port busy, output, 1 bit, high while a sweep is in progress.
REQ-008 SHALL have port done, output, 1 bit, high while in DONE.
REQ-009 SHALL have port pass, output, 1 bit, high in DONE when err_count==0.
REQ-010 SHALL have port err_count, output, 5 bits, number of failing vectors in the current or last sweep.
REQ-011 SHALL have port fail_valid, output, 1 bit, high once a failing vector has been captured.
REQ-012 SHALL have port fail_vec, output, 4 bits, the first failing vector of the sweep.

Function
REQ-013 SHALL compute the expected response as E=A&B, F=C&D, G=~(E|F), evaluated from the registered vec_out.
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE or DONE with start=1 SHALL transition to DRIVE with vec_out=0, err_count=0, fail_valid=0 and fail_vec=0 on the next cycle.
REQ-016 DRIVE SHALL last exactly 1 cycle and then go to SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by an internal down-counter, and then go to SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle and compare {e_in,f_in,g_in} against the expected value.
REQ-019 Any bit mismatch in SAMPLE SHALL add exactly 1 to err_count, regardless of how many bits mismatch.
REQ-020 The first mismatch of a sweep SHALL load fail_vec=vec_out and set fail_valid=1; later mismatches SHALL NOT change fail_vec.
REQ-021 SAMPLE with vec_out<15 SHALL increment vec_out and go to DRIVE; SAMPLE with vec_out==15 SHALL go to DONE with vec_out held at 15 (no wrap).
REQ-022 Each vector SHALL take SETTLE_CYCLES+2 cycles, so done SHALL rise 16*(SETTLE_CYCLES+2)+1 cycles after the cycle in which start is sampled.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-024 pass SHALL be 0 outside DONE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 The DONE outputs (done, pass, err_count, fail_vec, fail_valid) SHALL hold until start or rst.
REQ-027 err_count SHALL NOT overflow; its maximum is 16.

Reset
REQ-028 On rst=1, immediately and without a clock edge: state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0; settle counter cleared.
REQ-029 Assertion of rst mid-sweep SHALL abandon the sweep, and the block SHALL require a new start after rst deasserts.
REQ-030 While rst=1, start SHALL be ignored.

Verification
REQ-031 Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
REQ-032 Correct AOI model connected, SETTLE_CYCLES=2, start pulse -> vec_out steps 0..15; done=1 exactly 65 cycles after start is sampled; pass=1, err_count=0, fail_valid=0.
REQ-033 g_in tied to 0 -> done with pass=0, err_count=9, fail_valid=1, fail_vec=0.
REQ-034 e_in tied to 0 -> err_count=4, fail_vec=3 (4'b0011).
REQ-035 Second start while busy at vec_out=5 -> ignored and the sweep completes normally; rst at vec_out=5 -> IDLE, all outputs 0; a later start runs a full fresh sweep.
REQ-036 After the fail sweep in REQ-033, connect the correct model and pulse start -> counts are cleared on entry to DRIVE, and the sweep ends with pass=1, err_count=0.

Source files
------------

// File: rtl/aoi_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : aoi_vector_checker
// Description : Sweeps all 16 ABCD vectors into an AOI gate, checks the E/F/G
//               responses and reports error count and first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module aoi_vector_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       e_in,
    input  logic       f_in,
    input  logic       g_in,
    output logic [3:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] fail_vec
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] ERR_MAX  = 5'd16;

    logic [2:0] state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [4:0] err_q, err_d;
    logic       fvalid_q, fvalid_d;
    logic [3:0] fvec_q, fvec_d;
    logic [3:0] cnt_q, cnt_d;

    logic       exp_e, exp_f, exp_g;
    logic       mismatch;

    // Reference response is derived from the registered vector, not the inputs
    assign exp_e    = vec_q[0] & vec_q[1];
    assign exp_f    = vec_q[2] & vec_q[3];
    assign exp_g    = ~(exp_e | exp_f);
    assign mismatch = ({e_in, f_in, g_in} != {exp_e, exp_f, exp_g});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 4'd0;
            err_q    <= 5'd0;
            fvalid_q <= 1'b0;
            fvec_q   <= 4'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    vec_d    = 4'd0;
                    err_d    = 5'd0;
                    fvalid_d = 1'b0;
                    fvec_d   = 4'd0;
                end
            end
            S_DRIVE: begin
                state_d = S_SETTLE;
                cnt_d   = CNT_INIT;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 5'd1;
                    end
                    if (!fvalid_q) begin
                        fvalid_d = 1'b1;
                        fvec_d   = vec_q;
                    end
                end
                // Last vector holds at 15 rather than wrapping
                if (vec_q == 4'hF) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state_q)
            S_DRIVE, S_SETTLE, S_SAMPLE: busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = (err_q == 5'd0);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign vec_out    = vec_q;
    assign err_count  = err_q;
    assign fail_valid = fvalid_q;
    assign fail_vec   = fvec_q;

endmodule
`default_nettype wire

// File: tb/tb_aoi_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_aoi_vector_checker
// Description : Self-checking bench: AOI gate model with selectable faults
//               plus a vector-level reference of the expected sweep results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aoi_vector_checker;

    localparam int SETTLE = 2;
    localparam int PER_VEC = SETTLE + 2;
    localparam int DONE_CYC = 16 * PER_VEC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       e_in, f_in, g_in;
    logic [3:0] vec_out;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_vec;

    int         checks = 0;
    int         errors = 0;
    int         mode   = 0;     // 0 good, 1 G stuck-0, 2 E stuck-0, 3 random flips
    logic [2:0] flip [16];
    logic [2:0] resp;

    int         exp_err;
    int         exp_fv;
    bit         exp_fvalid;

    aoi_vector_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .e_in(e_in), .f_in(f_in), .g_in(g_in),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // Gate under test, with optional planted faults
    always_comb begin
        resp[2] = vec_out[0] & vec_out[1];
        resp[1] = vec_out[2] & vec_out[3];
        resp[0] = ~(resp[2] | resp[1]);
        case (mode)
            1: resp[0] = 1'b0;
            2: resp[2] = 1'b0;
            3: resp    = resp ^ flip[vec_out];
            default: resp = resp;
        endcase
    end
    assign {e_in, f_in, g_in} = resp;

    function automatic logic [2:0] ideal(input int v);
        bit e, f, g;
        e = ((v % 4) == 3);
        f = ((v / 4) == 3);
        g = !(e || f);
        return {e, f, g};
    endfunction

    function automatic logic [2:0] faulty(input int v, input int m);
        logic [2:0] r;
        r = ideal(v);
        if (m == 1) r[0] = 1'b0;
        if (m == 2) r[2] = 1'b0;
        if (m == 3) r = r ^ flip[v];
        return r;
    endfunction

    task automatic compute_expect(input int m);
        exp_err = 0;
        exp_fv = 0;
        exp_fvalid = 1'b0;
        for (int v = 0; v < 16; v++) begin
            if (faulty(v, m) != ideal(v)) begin
                if (!exp_fvalid) exp_fv = v;
                exp_fvalid = 1'b1;
                exp_err++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_final(input string tag);
        check({tag, "_done"},  {31'd0, done}, 32'd1);
        check({tag, "_pass"},  {31'd0, pass}, {31'd0, exp_err == 0});
        check({tag, "_err"},   {27'd0, err_count}, exp_err);
        check({tag, "_fvld"},  {31'd0, fail_valid}, {31'd0, exp_fvalid});
        check({tag, "_fvec"},  {28'd0, fail_vec}, exp_fv);
    endtask

    // Pulses start, follows the sweep cycle by cycle, checks the end state.
    task automatic run_sweep(input string tag, input int m, input bit poke);
        int first_done;
        logic [31:0] exp_vec;
        mode = m;
        compute_expect(m);
        first_done = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= DONE_CYC + 4; cyc++) begin
            if (done && first_done < 0) first_done = cyc;
            if (cyc == 1) begin
                check({tag, "_clr"}, {26'd0, err_count, fail_valid}, 32'd0);
                check({tag, "_clrv"}, {28'd0, fail_vec}, 32'd0);
            end
            exp_vec = (cyc < DONE_CYC) ? (cyc - 1) / PER_VEC : 15;
            if (cyc < DONE_CYC)
                check({tag, "_run"}, {25'd0, busy, done, pass, vec_out}, {25'd0, 3'b100, exp_vec[3:0]});
            else
                check({tag, "_end"}, {25'd0, busy, done, pass, vec_out},
                      {25'd0, 2'b01, exp_err == 0, exp_vec[3:0]});
            if (poke && cyc == 5 * PER_VEC + 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_latency"}, first_done, DONE_CYC);
        check_final(tag);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) flip[i] = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ignored", {24'd0, busy, done, pass, err_count[0], fail_valid, vec_out[2:0]}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", {16'd0, busy, done, pass, fail_valid, err_count, fail_vec, vec_out}, 32'd0);

        run_sweep("good", 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_final("good_hold");

        run_sweep("g0", 1, 1'b0);
        check("g0_err_const", {27'd0, err_count}, 32'd9);
        check("g0_fvec_const", {28'd0, fail_vec}, 32'd0);

        run_sweep("recover", 0, 1'b0);

        run_sweep("e0", 2, 1'b0);
        check("e0_err_const", {27'd0, err_count}, 32'd4);
        check("e0_fvec_const", {28'd0, fail_vec}, 32'd3);

        run_sweep("busy_start", 0, 1'b1);

        // Abandon a sweep with an asynchronous reset at vector 5
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 5 * PER_VEC + 2; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_vec", {28'd0, vec_out}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {16'd0, busy, done, pass, fail_valid, err_count, fail_vec, vec_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stay_idle", {29'd0, busy, done, pass}, 32'd0);
        check("stay_idle_vec", {28'd0, vec_out}, 32'd0);

        run_sweep("fresh", 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++)
                flip[i] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            run_sweep($sformatf("rand%0d", r), 3, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
